// File: rtl/firc_pkg.sv
// ---------------------------------------------------------------------------
// firc_pkg
// Shared widths, coefficient address range and feeder state type for the
// complex FIR interface. Used by the feeder and by the filter itself.
// ---------------------------------------------------------------------------
package firc_pkg;

  localparam int SAMP_W = 24;
  localparam int COEF_W = 27;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] COEF_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COEF_LAST  = ADDR_W'(15);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  // True for table addresses that hold a real coefficient (1..15).
  function automatic logic coefAddrValid(input logic [ADDR_W-1:0] addr);
    return (addr >= COEF_FIRST) && (addr <= COEF_LAST);
  endfunction

endpackage

// File: rtl/firc_samp_fifo.sv
// ---------------------------------------------------------------------------
// firc_samp_fifo
// Small synchronous FIFO holding packed {I,Q} samples for the feeder.
// Head entry is always presented on data_o; a push into an empty FIFO
// becomes visible on the cycle after the write (no bypass path).
//
// Ports
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset; empties FIFO, clears storage
//   push_i   write data_i at the edge (ignored when full)
//   data_i   word to write
//   pop_i    drop the head entry at the edge (ignored when empty)
//   data_o   current head entry
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
// ---------------------------------------------------------------------------
module firc_samp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wrPtr_q;
  logic [PTR_W:0]   rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

  // A full FIFO refuses a write even when the head is popped the same cycle.
  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  assign data_o = mem_q[rdPtr_q[PTR_W-1:0]];

  // Storage and pointers; storage is cleared so the head reads 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/firc_feeder.sv
// ---------------------------------------------------------------------------
// firc_feeder
// Transmit-side driver for the complex FIR filter. Keeps a host-written
// table of 15 complex coefficients, downloads it to the filter on request,
// then streams buffered I/Q samples while honouring StopIn back-pressure.
//
// Ports
//   Clk, Reset              clock, asynchronous active-low reset
//   CoefWr/CoefWrAddr/I/Q   host table write (addresses 1..15)
//   StartCoef               request a table download
//   CoefBusy                download in progress, table writes dropped
//   SrcValid/SrcReady/I/Q   upstream sample handshake
//   StopIn                  filter back-pressure
//   PushCoef/CoefAddr/I/Q   coefficient stream to the filter
//   PushIn/SampI/SampQ      sample stream to the filter
//   Streaming               feeder is in the streaming state
//   SampCount               samples pushed since the last completed download
// ---------------------------------------------------------------------------
module firc_feeder
  import firc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CoefWr,
  input  logic [ADDR_W-1:0] CoefWrAddr,
  input  logic [COEF_W-1:0] CoefWrI,
  input  logic [COEF_W-1:0] CoefWrQ,
  input  logic              StartCoef,
  output logic              CoefBusy,
  input  logic              SrcValid,
  output logic              SrcReady,
  input  logic [SAMP_W-1:0] SrcI,
  input  logic [SAMP_W-1:0] SrcQ,
  input  logic              StopIn,
  output logic              PushCoef,
  output logic [ADDR_W-1:0] CoefAddr,
  output logic [COEF_W-1:0] CoefI,
  output logic [COEF_W-1:0] CoefQ,
  output logic              PushIn,
  output logic [SAMP_W-1:0] SampI,
  output logic [SAMP_W-1:0] SampQ,
  output logic              Streaming,
  output logic [CNT_W-1:0]  SampCount
);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] loadCnt_q, loadCnt_d;
  logic              pushCoef_q, pushCoef_d;
  logic [ADDR_W-1:0] coefAddr_q, coefAddr_d;
  logic [COEF_W-1:0] coefI_q, coefI_d;
  logic [COEF_W-1:0] coefQ_q, coefQ_d;
  logic [CNT_W-1:0]  sampCount_q, sampCount_d;
  logic              readyEn_q;

  // Entry 0 exists only so the 4-bit index covers the array; it is never written.
  logic [COEF_W-1:0] tblI_q [16];
  logic [COEF_W-1:0] tblQ_q [16];
  logic              tblWrEn;

  logic                fifoPush;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [2*SAMP_W-1:0] fifoHead;

  assign CoefBusy  = (state_q == LOAD);
  assign Streaming = (state_q == STREAM);
  assign tblWrEn   = CoefWr & ~CoefBusy & coefAddrValid(CoefWrAddr);

  // readyEn_q holds SrcReady low through reset and rises at the first edge after release.
  assign SrcReady = readyEn_q & ~fifoFull;
  assign fifoPush = SrcValid & SrcReady;
  assign PushIn   = Streaming & ~fifoEmpty & ~StopIn;

  assign {SampI, SampQ} = fifoHead;
  assign PushCoef       = pushCoef_q;
  assign CoefAddr       = coefAddr_q;
  assign CoefI          = coefI_q;
  assign CoefQ          = coefQ_q;
  assign SampCount      = sampCount_q;

  firc_samp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*SAMP_W)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .push_i  (fifoPush),
    .data_i  ({SrcI, SrcQ}),
    .pop_i   (PushIn),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Host coefficient table; writes are accepted only outside a download.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin
        tblI_q[i] <= '0;
        tblQ_q[i] <= '0;
      end
    end else if (tblWrEn) begin
      tblI_q[CoefWrAddr[3:0]] <= CoefWrI;
      tblQ_q[CoefWrAddr[3:0]] <= CoefWrQ;
    end
  end

  // Next-state logic. The coefficient outputs are registered from the entry
  // the load counter will hold next, so address k appears k cycles after the
  // StartCoef edge. Leaving LOAD clears the sample count.
  always_comb begin
    state_d     = state_q;
    loadCnt_d   = loadCnt_q;
    pushCoef_d  = 1'b0;
    coefAddr_d  = '0;
    coefI_d     = '0;
    coefQ_d     = '0;
    sampCount_d = sampCount_q;

    if (PushIn && (sampCount_q != {CNT_W{1'b1}})) begin
      sampCount_d = sampCount_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (StartCoef) begin
          state_d   = LOAD;
          loadCnt_d = COEF_FIRST;
        end
      end
      LOAD: begin
        if (loadCnt_q == COEF_LAST) begin
          state_d     = STREAM;
          loadCnt_d   = '0;
          sampCount_d = '0;
        end else begin
          loadCnt_d = loadCnt_q + ADDR_W'(1);
        end
      end
      STREAM: begin
        if (StartCoef) begin
          state_d   = LOAD;
          loadCnt_d = COEF_FIRST;
        end
      end
      default: begin
        state_d   = IDLE;
        loadCnt_d = '0;
      end
    endcase

    if (state_d == LOAD) begin
      pushCoef_d = 1'b1;
      coefAddr_d = loadCnt_d;
      coefI_d    = tblI_q[loadCnt_d[3:0]];
      coefQ_d    = tblQ_q[loadCnt_d[3:0]];
    end
  end

  // State, load counter, registered coefficient outputs and sample count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      loadCnt_q   <= '0;
      pushCoef_q  <= 1'b0;
      coefAddr_q  <= '0;
      coefI_q     <= '0;
      coefQ_q     <= '0;
      sampCount_q <= '0;
      readyEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      loadCnt_q   <= loadCnt_d;
      pushCoef_q  <= pushCoef_d;
      coefAddr_q  <= coefAddr_d;
      coefI_q     <= coefI_d;
      coefQ_q     <= coefQ_d;
      sampCount_q <= sampCount_d;
      readyEn_q   <= 1'b1;
    end
  end

endmodule
